// File: rtl/align_pkg.sv
// -----------------------------------------------------------------------------
// align_pkg
// Shared definitions for align_sequencer: the sequencer state encoding, the
// number of byte groups handled by data_align, the "all groups disabled"
// mask that is refused as a configuration, and the popcount helper that turns
// a disabled-group mask into the compacted sample width.
// -----------------------------------------------------------------------------
package align_pkg;

    localparam int GROUPS = 4;

    // Disabling every group would leave a zero-byte sample, so it is refused.
    localparam logic [GROUPS-1:0] CFG_ALL_DISABLED = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    // Number of set bits in a 4-bit mask (0..4).
    function automatic logic [2:0] popcount4(input logic [GROUPS-1:0] v);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < GROUPS; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/align_sequencer.sv
// -----------------------------------------------------------------------------
// align_sequencer
// Control block in front of data_align. Owns the disabledGroups mask that
// drives data_align's mux selects and only changes it at a safe point: the
// sample gate is closed, the data_align pipeline is allowed to drain, the new
// mask is applied, and the gate stays closed until the select registers have
// settled. Also reports the compacted sample width and counts accepted
// samples since the last configuration was applied.
//
// Ports:
//   clk              system clock
//   rst              asynchronous, active-high reset
//   run_en           level, 1 = capture enabled
//   cfg_wr           one-cycle strobe, load cfg_groups
//   cfg_groups       requested disabled-group mask
//   cfg_busy         1 while draining / loading / settling
//   cfg_err          one-cycle pulse, configuration rejected
//   disabledGroups   applied mask, registered, to data_align
//   bytes_per_sample 4 - popcount(disabledGroups), 1..4
//   up_tvalid        upstream sample valid
//   up_tready        upstream ready (dn_tready gated)
//   dn_tvalid        valid towards data_align (up_tvalid gated)
//   dn_tready        ready from data_align side
//   sample_count     transfers since the last configuration apply (saturating)
// -----------------------------------------------------------------------------
module align_sequencer
    import align_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int CW            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              cfg_wr,
    input  logic [GROUPS-1:0] cfg_groups,
    output logic              cfg_busy,
    output logic              cfg_err,
    output logic [GROUPS-1:0] disabledGroups,
    output logic [2:0]        bytes_per_sample,
    input  logic              up_tvalid,
    output logic              up_tready,
    output logic              dn_tvalid,
    input  logic              dn_tready,
    output logic [CW-1:0]     sample_count
);

    // The wait counter is loaded with N-1 on entry and the state is left when
    // it reads zero, giving exactly N cycles in DRAIN / SETTLE. A zero
    // parameter still costs one cycle since the state has to be visited.
    localparam int DRAIN_LOAD  = (DRAIN_CYCLES  > 0) ? DRAIN_CYCLES  - 1 : 0;
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int WAIT_MAX    = (DRAIN_LOAD > SETTLE_LOAD) ? DRAIN_LOAD : SETTLE_LOAD;
    localparam int WAIT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [WAIT_W-1:0] DRAIN_INIT  = WAIT_W'(DRAIN_LOAD);
    localparam logic [WAIT_W-1:0] SETTLE_INIT = WAIT_W'(SETTLE_LOAD);
    localparam logic [CW-1:0]     COUNT_MAX   = {CW{1'b1}};

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [GROUPS-1:0]   pending_q, pending_d;
    logic [GROUPS-1:0]   groups_q, groups_d;
    logic [2:0]          bps_q, bps_d;
    logic                gate_q, gate_d;
    logic                err_q, err_d;
    logic [CW-1:0]       count_q, count_d;

    logic                cfg_accept;
    logic                cfg_reject;
    logic                xfer;
    logic                enter_load;

    assign cfg_accept = cfg_wr && (cfg_groups != CFG_ALL_DISABLED);
    assign cfg_reject = cfg_wr && (cfg_groups == CFG_ALL_DISABLED);
    assign xfer       = up_tvalid && up_tready;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            pending_q <= '0;
            groups_q  <= '0;
            bps_q     <= 3'd4;
            gate_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            groups_q  <= groups_d;
            bps_q     <= bps_d;
            gate_q    <= gate_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_accept)  state_d = ST_DRAIN;
                else if (run_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_accept)   state_d = ST_DRAIN;
                else if (!run_en) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // A new accepted write keeps us here with a fresh count.
                if (!cfg_accept) begin
                    if (wait_q == '0) state_d = ST_LOAD;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
            end
            ST_LOAD: begin
                if (cfg_accept) state_d = ST_DRAIN;
                else            state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cfg_accept) begin
                    state_d = ST_DRAIN;
                end else if (wait_q == '0) begin
                    state_d = run_en ? ST_RUN : ST_IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter (re)loads on entry to DRAIN and SETTLE.
        if (cfg_accept)                wait_d = DRAIN_INIT;
        else if (state_q == ST_LOAD)   wait_d = SETTLE_INIT;
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    // The mask is applied on the edge that enters LOAD so it is already
    // visible to data_align during the LOAD cycle; its select registers then
    // follow one cycle later, which SETTLE covers.
    assign enter_load = (state_d == ST_LOAD);

    always_comb begin
        pending_d = cfg_accept ? cfg_groups : pending_q;
        groups_d  = groups_q;
        bps_d     = bps_q;
        count_d   = count_q;
        err_d     = cfg_reject;
        gate_d    = (state_d == ST_RUN);

        if (enter_load) begin
            groups_d = pending_q;
            bps_d    = 3'd4 - popcount4(pending_q);
            count_d  = '0;
        end else if (xfer && (count_q != COUNT_MAX)) begin
            count_d  = count_q + CW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_busy         = (state_q == ST_DRAIN) || (state_q == ST_LOAD) ||
                           (state_q == ST_SETTLE);
        cfg_err          = err_q;
        disabledGroups   = groups_q;
        bytes_per_sample = bps_q;
        sample_count     = count_q;
        dn_tvalid        = up_tvalid && gate_q;
        up_tready        = dn_tready && gate_q;
    end

endmodule

// File: tb/tb_align_sequencer.sv
// -----------------------------------------------------------------------------
// tb_align_sequencer
// Self-checking bench for align_sequencer. Inputs are driven just after the
// rising edge and outputs are sampled shortly afterwards, well away from the
// next rising edge. Expected applied configurations are queued when the
// configuration write is driven and compared when the gate reopens.
// -----------------------------------------------------------------------------
module tb_align_sequencer;

    logic        clk;
    logic        rst;
    logic        run_en;
    logic        cfg_wr;
    logic [3:0]  cfg_groups;
    logic        cfg_busy;
    logic        cfg_err;
    logic [3:0]  disabledGroups;
    logic [2:0]  bytes_per_sample;
    logic        up_tvalid;
    logic        up_tready;
    logic        dn_tvalid;
    logic        dn_tready;
    logic [31:0] sample_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] bps;
    } exp_cfg_t;

    exp_cfg_t exp_q[$];

    logic saw_0001_in_run;

    align_sequencer #(
        .DRAIN_CYCLES (2),
        .SETTLE_CYCLES(1),
        .CW           (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .run_en          (run_en),
        .cfg_wr          (cfg_wr),
        .cfg_groups      (cfg_groups),
        .cfg_busy        (cfg_busy),
        .cfg_err         (cfg_err),
        .disabledGroups  (disabledGroups),
        .bytes_per_sample(bytes_per_sample),
        .up_tvalid       (up_tvalid),
        .up_tready       (up_tready),
        .dn_tvalid       (dn_tvalid),
        .dn_tready       (dn_tready),
        .sample_count    (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watches for the superseded 0001 mask ever being used while samples flow.
    always @(negedge clk) begin
        if (rst === 1'b0 && dn_tvalid === 1'b1 && disabledGroups === 4'b0001)
            saw_0001_in_run <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock cycle: inputs applied just after the rising edge, outputs
    // sampled 2 time units after the edge.
    task automatic cyc(input logic re, input logic wr, input logic [3:0] g,
                       input logic tv, input logic tr);
        @(posedge clk);
        #1;
        run_en     = re;
        cfg_wr     = wr;
        cfg_groups = g;
        up_tvalid  = tv;
        dn_tready  = tr;
        #1;
    endtask

    task automatic test_reset();
        exp_cfg_t e;
        rst = 1'b1; run_en = 1'b0; cfg_wr = 1'b0; cfg_groups = 4'h0;
        up_tvalid = 1'b1; dn_tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (disabledGroups !== 4'h0) begin failures++; $display("FAIL reset_groups got=%b exp=%b", disabledGroups, 4'h0); end
        checks++; if (bytes_per_sample !== 3'd4) begin failures++; $display("FAIL reset_bps got=%0d exp=4", bytes_per_sample); end
        checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", cfg_busy); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
        checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
        checks++; if (dn_tvalid !== 1'b0 || up_tready !== 1'b0) begin failures++; $display("FAIL reset_gate got dn_tvalid=%b up_tready=%b exp 0/0", dn_tvalid, up_tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        up_tvalid = 1'b0;
        e.mask = 4'h0; e.bps = 3'd4;
        exp_q.push_back(e);
        $display("reset done");
    endtask

    task automatic test_run_basic();
        int beats;
        exp_cfg_t e;
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (dn_tvalid !== 1'b0) begin failures++; $display("FAIL run_first_cycle_gate got=%b exp=0", dn_tvalid); end
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
            checks++; if (dn_tvalid !== 1'b1) begin failures++; $display("FAIL run_beat%0d got=%b exp=1", i, dn_tvalid); end
            if (dn_tvalid === 1'b1 && up_tready === 1'b1) beats++;
            $display("beat %0d dn_tvalid=%b", i, dn_tvalid);
        end
        checks++; if (beats != 10) begin failures++; $display("FAIL run_beats got=%0d exp=10", beats); end
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        checks++; if (sample_count !== 32'd10) begin failures++; $display("FAIL run_count got=%0d exp=10", sample_count); end
        e = exp_q.pop_front();
        checks++; if (disabledGroups !== e.mask || bytes_per_sample !== e.bps) begin failures++; $display("FAIL run_cfg got=%b/%0d exp=%b/%0d", disabledGroups, bytes_per_sample, e.mask, e.bps); end
    endtask

    task automatic test_cfg_apply();
        exp_cfg_t e;
        cyc(1'b1, 1'b1, 4'b0011, 1'b1, 1'b1);
        e.mask = 4'b0011; e.bps = 3'd2;
        exp_q.push_back(e);
        checks++; if (dn_tvalid !== 1'b1 || cfg_busy !== 1'b0) begin failures++; $display("FAIL apply_strobe_cycle got tvalid=%b busy=%b exp 1/0", dn_tvalid, cfg_busy); end
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
            checks++; if (cfg_busy !== 1'b1 || dn_tvalid !== 1'b0) begin failures++; $display("FAIL apply_busy_c%0d got busy=%b tvalid=%b exp 1/0", i, cfg_busy, dn_tvalid); end
            if (i == 2) begin
                checks++; if (disabledGroups !== 4'h0) begin failures++; $display("FAIL apply_drain_groups got=%b exp=0000", disabledGroups); end
            end
            if (i == 3) begin
                checks++; if (disabledGroups !== 4'b0011) begin failures++; $display("FAIL apply_load_groups got=%b exp=0011", disabledGroups); end
                checks++; if (bytes_per_sample !== 3'd2) begin failures++; $display("FAIL apply_load_bps got=%0d exp=2", bytes_per_sample); end
                checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL apply_load_count got=%0d exp=0", sample_count); end
            end
        end
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (cfg_busy !== 1'b0 || dn_tvalid !== 1'b1) begin failures++; $display("FAIL apply_reopen got busy=%b tvalid=%b exp 0/1", cfg_busy, dn_tvalid); end
        checks++; if (sample_count !== 32'd0) begin failures++; $display("FAIL apply_reopen_count got=%0d exp=0", sample_count); end
        e = exp_q.pop_front();
        checks++; if (disabledGroups !== e.mask || bytes_per_sample !== e.bps) begin failures++; $display("FAIL apply_cfg got=%b/%0d exp=%b/%0d", disabledGroups, bytes_per_sample, e.mask, e.bps); end
        $display("cfg applied mask=%b bps=%0d", disabledGroups, bytes_per_sample);
    endtask

    task automatic test_overwrite();
        exp_cfg_t e;
        saw_0001_in_run = 1'b0;
        cyc(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
        e.mask = 4'b0001; e.bps = 3'd3;
        exp_q.push_back(e);
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (disabledGroups !== 4'b0001) begin failures++; $display("FAIL ovw_first_load got=%b exp=0001", disabledGroups); end
        // SETTLE cycle: newer write supersedes the queued one.
        cyc(1'b1, 1'b1, 4'b0111, 1'b1, 1'b1);
        exp_q.delete();
        e.mask = 4'b0111; e.bps = 3'd1;
        exp_q.push_back(e);
        checks++; if (cfg_busy !== 1'b1 || dn_tvalid !== 1'b0) begin failures++; $display("FAIL ovw_settle got busy=%b tvalid=%b exp 1/0", cfg_busy, dn_tvalid); end
        for (int i = 5; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
            checks++; if (cfg_busy !== 1'b1 || dn_tvalid !== 1'b0) begin failures++; $display("FAIL ovw_busy_c%0d got busy=%b tvalid=%b exp 1/0", i, cfg_busy, dn_tvalid); end
        end
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (dn_tvalid !== 1'b1) begin failures++; $display("FAIL ovw_reopen got=%b exp=1", dn_tvalid); end
        e = exp_q.pop_front();
        checks++; if (disabledGroups !== e.mask || bytes_per_sample !== e.bps) begin failures++; $display("FAIL ovw_cfg got=%b/%0d exp=%b/%0d", disabledGroups, bytes_per_sample, e.mask, e.bps); end
        checks++; if (saw_0001_in_run !== 1'b0) begin failures++; $display("FAIL ovw_stale_in_run got=%b exp=0", saw_0001_in_run); end
        $display("cfg applied mask=%b bps=%0d", disabledGroups, bytes_per_sample);
    endtask

    task automatic test_reject();
        logic [31:0] s0;
        cyc(1'b1, 1'b1, 4'hF, 1'b1, 1'b1);
        s0 = sample_count;
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL rej_err_pulse got=%b exp=1", cfg_err); end
        checks++; if (dn_tvalid !== 1'b1 || cfg_busy !== 1'b0) begin failures++; $display("FAIL rej_state got tvalid=%b busy=%b exp 1/0", dn_tvalid, cfg_busy); end
        checks++; if (disabledGroups !== 4'b0111) begin failures++; $display("FAIL rej_groups got=%b exp=0111", disabledGroups); end
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL rej_err_clear got=%b exp=0", cfg_err); end
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        checks++; if (sample_count !== s0 + 32'd3) begin failures++; $display("FAIL rej_no_gap got=%0d exp=%0d", sample_count, s0 + 32'd3); end
        $display("cfg rejected mask=1111 count=%0d", sample_count);
    endtask

    task automatic test_backpressure();
        logic [31:0] s0;
        logic        tr;
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        s0 = sample_count;
        for (int i = 0; i < 8; i++) begin
            tr = (i % 2 == 0);
            cyc(1'b1, 1'b0, 4'h0, 1'b1, tr);
            checks++; if (up_tready !== tr) begin failures++; $display("FAIL bp_ready_c%0d got=%b exp=%b", i, up_tready, tr); end
        end
        cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        checks++; if (sample_count !== s0 + 32'd4) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", sample_count, s0 + 32'd4); end
        $display("backpressure count=%0d", sample_count);
    endtask

    task automatic test_reset_mid();
        exp_cfg_t e;
        cyc(1'b1, 1'b1, 4'b1100, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL rstmid_drain got=%b exp=1", cfg_busy); end
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++; if (disabledGroups !== 4'h0 || bytes_per_sample !== 3'd4) begin failures++; $display("FAIL rstmid_cfg got=%b/%0d exp=0000/4", disabledGroups, bytes_per_sample); end
        checks++; if (cfg_busy !== 1'b0 || sample_count !== 32'd0) begin failures++; $display("FAIL rstmid_busy_count got=%b/%0d exp=0/0", cfg_busy, sample_count); end
        checks++; if (dn_tvalid !== 1'b0 || up_tready !== 1'b0) begin failures++; $display("FAIL rstmid_gate got=%b/%b exp=0/0", dn_tvalid, up_tready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        e.mask = 4'h0; e.bps = 3'd4;
        exp_q.push_back(e);
        cyc(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        checks++; if (dn_tvalid !== 1'b1) begin failures++; $display("FAIL rstmid_run got=%b exp=1", dn_tvalid); end
        e = exp_q.pop_front();
        checks++; if (disabledGroups !== e.mask || bytes_per_sample !== e.bps) begin failures++; $display("FAIL rstmid_after_cfg got=%b/%0d exp=%b/%0d", disabledGroups, bytes_per_sample, e.mask, e.bps); end
        $display("reset mid-sequence mask=%b", disabledGroups);
    endtask

    initial begin
        saw_0001_in_run = 1'b0;
        test_reset();
        test_run_basic();
        test_cfg_apply();
        test_overwrite();
        test_reject();
        test_backpressure();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
